// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding memory requests and queues words for decode.
// Optional build macro IFQ_BYPASS_EN forwards an ack straight to decode when the queue is empty.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_016c
) (
  input  logic                    clk,
  input  logic                    reset_l,
  output logic                    mem_req,
  output logic [31:0]             mem_addr,
  input  logic                    mem_ack,
  input  logic [31:0]             mem_rdata,
  output logic                    instr_valid,
  output logic [31:0]             instr,
  output logic [31:0]             instr_pc,
  input  logic                    instr_ready,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  state_e          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic [31:0]     pc_q, pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     instr_pc_q, instr_pc_d;
  entry_t          fifo_q [DEPTH];
  entry_t          fifo_d [DEPTH];

  logic            push;
  logic            pop;
  logic            bypass_take;
  logic [31:0]     redir_pc;
  logic            unused_ok;

  assign redir_pc  = {redirect_pc[31:2], 2'b00};
  assign unused_ok = ^redirect_pc[1:0];

  // Redirect wins over any same-cycle pop.
  assign pop = valid_q && instr_ready && !redirect;

`ifdef IFQ_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit  = (state_q == ST_WAIT) && mem_ack && !redirect && (count_q == '0);
  assign bypass_take = bypass_hit && instr_ready;
  assign instr_valid = valid_q || bypass_hit;
  assign instr       = bypass_hit ? mem_rdata : instr_q;
  assign instr_pc    = bypass_hit ? pc_q : instr_pc_q;
`else
  assign bypass_take = 1'b0;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
`endif

  assign mem_req  = mem_req_q;
  assign mem_addr = pc_q;
  assign count    = count_q;

  // Fetch FSM: request issue, ack capture and discard of redirected requests.
  always_comb begin
    state_d   = state_q;
    mem_req_d = 1'b0;
    pc_d      = pc_q;
    push      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          pc_d = redir_pc;
        end else if (count_q < CW'(DEPTH)) begin
          mem_req_d = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          pc_d    = redir_pc;
          state_d = mem_ack ? ST_IDLE : ST_DROP;
        end else if (mem_ack) begin
          push    = !bypass_take;
          pc_d    = pc_q + 32'd4;
          state_d = ST_IDLE;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      ST_DROP: begin
        if (redirect) begin
          pc_d = redir_pc;
        end
        if (mem_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Queue pointers, occupancy and the registered head presented to decode.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    fifo_d     = fifo_q;
    if (redirect) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        fifo_d[tail_q] = '{pc: pc_q, data: mem_rdata};
        tail_d         = tail_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      // A push into a queue that is (or becomes) empty lands directly at the head.
      if (push && (count_q == CW'(pop))) begin
        instr_d    = mem_rdata;
        instr_pc_d = pc_q;
      end else if (pop) begin
        instr_d    = fifo_q[head_d].data;
        instr_pc_d = fifo_q[head_d].pc;
      end
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      pc_q       <= RESET_PC;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      fifo_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      fifo_q     <= fifo_d;
    end
  end

endmodule
